// File: rtl/baud_tick_gen_if.sv
// Control and tick bundle between a UART baud generator and its rx/tx users.
// The master drives run/clear/divisor requests; the slave returns the tick enables.
interface baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              enable;
    logic              sync_clear;
    logic              div_load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              s_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic              cfg_err;

    modport master (
        output enable, sync_clear, div_load, div_int, div_frac,
        input  s_tick, mid_tick, bit_tick, cfg_err
    );

    modport slave (
        input  enable, sync_clear, div_load, div_int, div_frac,
        output s_tick, mid_tick, bit_tick, cfg_err
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional clock-enable generator for the UART: divides clk by INT + FRAC/2^FRAC_W
// and emits registered one-cycle oversample, mid-bit and end-of-bit pulses.
module baud_tick_gen #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OSR      = 16,
    parameter int DEF_INT  = 651,
    parameter int DEF_FRAC = 1
) (
    input logic            clk,
    input logic            reset,
    baud_tick_gen_if.slave bus
);
    localparam int SC_W = $clog2(OSR);

    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_pend;
    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_facc;
    logic [SC_W-1:0]   r_scnt;
    logic              r_s_tick;
    logic              r_mid_tick;
    logic              r_bit_tick;
    logic              r_cfg_err;

    logic              w_load_ok;
    logic              w_load_bad;
    logic [FRAC_W:0]   w_sum;
    logic [DIV_W-1:0]  w_reload_cnt;

    assign w_load_ok    = bus.div_load && (bus.div_int >= DIV_W'(2));
    assign w_load_bad   = bus.div_load && !w_load_ok;
    // The fractional carry stretches this interval by one cycle.
    assign w_sum        = {1'b0, r_facc} + {1'b0, r_act_frac};
    assign w_reload_cnt = r_act_int - DIV_W'(1) + DIV_W'(w_sum[FRAC_W]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_act_int   <= DIV_W'(DEF_INT);
            r_act_frac  <= FRAC_W'(DEF_FRAC);
            r_pend_int  <= '0;
            r_pend_frac <= '0;
            r_pend      <= 1'b0;
            r_cnt       <= DIV_W'(DEF_INT - 1);
            r_facc      <= '0;
            r_scnt      <= '0;
            r_s_tick    <= 1'b0;
            r_mid_tick  <= 1'b0;
            r_bit_tick  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err  <= w_load_bad;
            r_s_tick   <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
            if (bus.sync_clear) begin
                r_facc <= '0;
                r_scnt <= '0;
                r_pend <= 1'b0;
                if (w_load_ok) begin
                    r_act_int  <= bus.div_int;
                    r_act_frac <= bus.div_frac;
                    r_cnt      <= bus.div_int - DIV_W'(1);
                end else if (r_pend) begin
                    r_act_int  <= r_pend_int;
                    r_act_frac <= r_pend_frac;
                    r_cnt      <= r_pend_int - DIV_W'(1);
                end else begin
                    r_cnt <= r_act_int - DIV_W'(1);
                end
            end else if (w_load_ok && !bus.enable) begin
                r_act_int  <= bus.div_int;
                r_act_frac <= bus.div_frac;
                r_cnt      <= bus.div_int - DIV_W'(1);
                r_facc     <= '0;
                r_pend     <= 1'b0;
            end else begin
                if (bus.enable) begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end else begin
                        r_s_tick   <= 1'b1;
                        r_mid_tick <= (r_scnt == SC_W'(OSR / 2 - 1));
                        r_bit_tick <= (r_scnt == SC_W'(OSR - 1));
                        r_scnt     <= r_scnt + SC_W'(1);
                        if (r_pend) begin
                            // Fresh divisor starts with an empty accumulator, so no carry yet.
                            r_act_int  <= r_pend_int;
                            r_act_frac <= r_pend_frac;
                            r_cnt      <= r_pend_int - DIV_W'(1);
                            r_facc     <= r_pend_frac;
                            r_pend     <= 1'b0;
                        end else begin
                            r_cnt  <= w_reload_cnt;
                            r_facc <= w_sum[FRAC_W-1:0];
                        end
                    end
                end
                // Placed last so a request in the reload cycle is kept as pending.
                if (w_load_ok) begin
                    r_pend      <= 1'b1;
                    r_pend_int  <= bus.div_int;
                    r_pend_frac <= bus.div_frac;
                end
            end
        end
    end

    assign bus.s_tick   = r_s_tick;
    assign bus.mid_tick = r_mid_tick;
    assign bus.bit_tick = r_bit_tick;
    assign bus.cfg_err  = r_cfg_err;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: tick spacing is predicted from the running-sum rule
// floor(n*frac/2^FRAC_W) and compared in enabled-cycle time.
module tb_baud_tick_gen;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) intf ();

    baud_tick_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .DEF_INT(651), .DEF_FRAC(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(intf)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ecyc = 0;

    // Enabled-cycle clock: counts only edges where the divider is allowed to run.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && intf.enable && !intf.sync_clear) ecyc <= ecyc + 1;
    end

    int m_int, m_frac, m_n, m_scnt, m_expect, m_last, m_last_cyc;
    int p_int, p_frac;
    bit m_pend;

    function automatic int carry_at(input int n, input int frac);
        return ((n * frac) >> FRAC_W) - (((n - 1) * frac) >> FRAC_W);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_restart(input int di, input int df, input bit clr_scnt);
        m_int    = di;
        m_frac   = df;
        m_n      = 0;
        m_expect = di;
        m_last   = ecyc;
        m_pend   = 1'b0;
        if (clr_scnt) m_scnt = 0;
    endtask

    task automatic wait_tick(input bit stall, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            intf.enable = stall ? ($urandom_range(3) != 0) : 1'b1;
            cycle();
            if (intf.s_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        intf.enable = 1'b1;
    endtask

    task automatic on_tick(input string tag);
        check({tag, " interval"}, ecyc - m_last, m_expect);
        check({tag, " mid"}, int'(intf.mid_tick), int'(m_scnt == OSR / 2 - 1));
        check({tag, " bit"}, int'(intf.bit_tick), int'(m_scnt == OSR - 1));
        m_scnt     = (m_scnt + 1) % OSR;
        m_last     = ecyc;
        m_last_cyc = cyc;
        if (m_pend) begin
            m_int  = p_int;
            m_frac = p_frac;
            m_n    = 1;
            m_pend = 1'b0;
        end else begin
            m_n++;
        end
        m_expect = m_int + carry_at(m_n, m_frac);
    endtask

    task automatic run_ticks(input string tag, input int n, input bit stall);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_tick(stall, 8 * m_expect + 50, ok);
            if (!ok) begin
                check({tag, " timeout"}, 0, 1);
                return;
            end
            on_tick(tag);
        end
    endtask

    task automatic load_disabled(input int di, input int df);
        intf.enable   = 1'b0;
        intf.div_load = 1'b1;
        intf.div_int  = DIV_W'(di);
        intf.div_frac = FRAC_W'(df);
        cycle();
        intf.div_load = 1'b0;
        model_restart(di, df, 1'b0);
    endtask

    task automatic load_pending(input int di, input int df);
        intf.enable   = 1'b1;
        intf.div_load = 1'b1;
        intf.div_int  = DIV_W'(di);
        intf.div_frac = FRAC_W'(df);
        cycle();
        intf.div_load = 1'b0;
        check("pend no tick", int'(intf.s_tick), 0);
        p_int  = di;
        p_frac = df;
        m_pend = 1'b1;
    endtask

    task automatic bad_load(input int di);
        intf.enable   = 1'b1;
        intf.div_load = 1'b1;
        intf.div_int  = DIV_W'(di);
        cycle();
        intf.div_load = 1'b0;
        check("cfg_err pulse", int'(intf.cfg_err), 1);
        cycle();
        check("cfg_err drop", int'(intf.cfg_err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int di, df;
        intf.enable     = 1'b1;
        intf.sync_clear = 1'b0;
        intf.div_load   = 1'b0;
        intf.div_int    = '0;
        intf.div_frac   = '0;
        m_scnt          = 0;

        repeat (3) @(negedge clk);
        check("rst s_tick", int'(intf.s_tick), 0);
        check("rst mid", int'(intf.mid_tick), 0);
        check("rst bit", int'(intf.bit_tick), 0);
        check("rst cfg_err", int'(intf.cfg_err), 0);
        reset = 1'b1;
        model_restart(651, 1, 1'b1);
        run_ticks("default", 17, 1'b0);

        load_disabled(4, 8);
        run_ticks("i4f8", 8, 1'b0);

        intf.sync_clear = 1'b1;
        intf.div_load   = 1'b1;
        intf.div_int    = DIV_W'(2);
        intf.div_frac   = '0;
        cycle();
        check("clr+load no tick", int'(intf.s_tick), 0);
        intf.sync_clear = 1'b0;
        intf.div_load   = 1'b0;
        model_restart(2, 0, 1'b1);
        run_ticks("i2", 32, 1'b0);

        load_disabled(5, 3);
        run_ticks("i5f3", 2, 1'b0);
        bad_load(1);
        run_ticks("after int1", 4, 1'b0);
        bad_load(0);
        run_ticks("after int0", 4, 1'b0);

        load_disabled(10, 0);
        run_ticks("i10", 2, 1'b0);
        cycle();
        load_pending(7, 5);
        load_pending(6, 0);
        run_ticks("pending", 4, 1'b0);

        cycle();
        cycle();
        intf.enable = 1'b0;
        repeat (7) cycle();
        check("stall no tick", int'(intf.s_tick), 0);
        begin
            bit ok;
            int prev_cyc;
            prev_cyc = m_last_cyc;
            wait_tick(1'b0, 100, ok);
            check("stall found", int'(ok), 1);
            check("stall wall", cyc - prev_cyc, m_expect + 7);
            on_tick("stall");
        end

        cycle();
        cycle();
        intf.sync_clear = 1'b1;
        cycle();
        check("clr no tick", int'(intf.s_tick), 0);
        intf.sync_clear = 1'b0;
        model_restart(m_int, m_frac, 1'b1);
        run_ticks("after clr", 16, 1'b0);

        for (int r = 0; r < 6; r++) begin
            di = $urandom_range(20, 2);
            df = $urandom_range(15, 0);
            load_disabled(di, df);
            run_ticks("rnd", 12, 1'b1);
            di = $urandom_range(20, 2);
            df = $urandom_range(15, 0);
            load_pending(di, df);
            run_ticks("rnd pend", 12, 1'b1);
        end

        run_ticks("pre rst", 1, 1'b0);
        check("pre rst s_tick", int'(intf.s_tick), 1);
        #1 reset = 1'b0;
        #1;
        check("async s_tick", int'(intf.s_tick), 0);
        check("async mid", int'(intf.mid_tick), 0);
        check("async bit", int'(intf.bit_tick), 0);
        check("async cfg_err", int'(intf.cfg_err), 0);
        @(negedge clk);
        reset = 1'b1;
        model_restart(651, 1, 1'b1);
        run_ticks("post rst", 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
